periph_err_slave: RTL and testbench

Error responder at the slave end of the cluster peripheral interconnect. It sits on the peripheral port that the crossbar decodes as the error slave and terminates every request it receives with an error response (`r_opc_o = 1`). Responses return in order after a fixed latency, and the block bounds its outstanding requests. For debug software it keeps a saturating error counter and a capture of the first offending access since the last clear, and raises a one-cycle interrupt when that capture is taken.

---
 rtl/periph_err_slave.sv | 144 ++++++++++++++
 tb/tb_periph_err_slave.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/periph_err_slave.sv
// Error slave for the cluster peripheral interconnect: answers every request with r_opc_o = 1
// after a fixed latency, and keeps a saturating error count plus a first-error capture.
module periph_err_slave #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = 4,
  parameter int unsigned ID_WIDTH        = 13,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hBADCAB1E,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_opc_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  input  logic                  clear_i,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [ID_WIDTH-1:0]   err_id_o,
  output logic                  err_we_n_o,
  output logic                  err_irq_o
);

  localparam int unsigned PendW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PendW-1:0] MaxPend = PendW'(MAX_OUTSTANDING);

  logic [PendW-1:0] pending_q, pending_d;

  logic [RESP_LATENCY-1:0]               vld_q, vld_d;
  logic [RESP_LATENCY-1:0][ID_WIDTH-1:0] id_q, id_d;
  logic [RESP_LATENCY-1:0]               we_n_q, we_n_d;

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [ID_WIDTH-1:0]   err_id_q, err_id_d;
  logic                  err_we_n_q, err_we_n_d;
  logic                  irq_q, irq_d;

  logic accept;
  logic resp_valid;
  logic unused_inputs;

  assign unused_inputs = ^{wdata_i, be_i};

  assign resp_valid = vld_q[RESP_LATENCY-1];
  // A slot frees up in the same cycle the oldest response leaves.
  assign gnt_o      = (pending_q < MaxPend) || resp_valid;
  assign accept     = req_i && gnt_o;

  always_comb begin
    pending_d = pending_q;
    if (accept && !resp_valid) begin
      pending_d = pending_q + 1'b1;
    end else if (!accept && resp_valid) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_comb begin
    vld_d     = '0;
    id_d      = '0;
    we_n_d    = '0;
    vld_d[0]  = accept;
    id_d[0]   = id_i;
    we_n_d[0] = wen_i;
    for (int unsigned k = 1; k < RESP_LATENCY; k++) begin
      vld_d[k]  = vld_q[k-1];
      id_d[k]   = id_q[k-1];
      we_n_d[k] = we_n_q[k-1];
    end
  end

  // Clear is applied before a same-cycle accept, so the accept re-arms the capture.
  always_comb begin
    cnt_d       = clear_i ? '0 : cnt_q;
    err_valid_d = clear_i ? 1'b0 : err_valid_q;
    err_addr_d  = err_addr_q;
    err_id_d    = err_id_q;
    err_we_n_d  = err_we_n_q;
    irq_d       = 1'b0;
    if (accept) begin
      if (cnt_d != '1) begin
        cnt_d = cnt_d + 1'b1;
      end
      if (!err_valid_d) begin
        err_valid_d = 1'b1;
        err_addr_d  = add_i;
        err_id_d    = id_i;
        err_we_n_d  = wen_i;
        irq_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q   <= '0;
      vld_q       <= '0;
      id_q        <= '0;
      we_n_q      <= '0;
      cnt_q       <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_id_q    <= '0;
      err_we_n_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      vld_q       <= vld_d;
      id_q        <= id_d;
      we_n_q      <= we_n_d;
      cnt_q       <= cnt_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_id_q    <= err_id_d;
      err_we_n_q  <= err_we_n_d;
      irq_q       <= irq_d;
    end
  end

  assign r_valid_o   = resp_valid;
  assign r_opc_o     = resp_valid;
  assign r_id_o      = resp_valid ? id_q[RESP_LATENCY-1] : '0;
  assign r_rdata_o   = (resp_valid && we_n_q[RESP_LATENCY-1]) ? ERR_DATA : '0;
  assign err_cnt_o   = cnt_q;
  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_id_o    = err_id_q;
  assign err_we_n_o  = err_we_n_q;
  assign err_irq_o   = irq_q;

endmodule

// File: tb/tb_periph_err_slave.sv
// Randomized bench for periph_err_slave: two instances (full-throughput and backpressured
// configurations) compared cycle by cycle against a response-schedule reference model.
module tb_periph_err_slave;

  localparam int NCYC = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        wen   [2];
  logic        clr   [2];
  logic [31:0] add   [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic [12:0] id    [2];

  logic        gnt   [2];
  logic        rv    [2];
  logic        opc   [2];
  logic [31:0] rdata [2];
  logic [12:0] rid   [2];
  logic        ev    [2];
  logic [31:0] eaddr [2];
  logic [12:0] eid   [2];
  logic        ewe   [2];
  logic        irq   [2];
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  // Instance a: latency 2, two outstanding, 4-bit counter. Instance b: latency 3, one outstanding.
  periph_err_slave #(
    .RESP_LATENCY(2), .MAX_OUTSTANDING(2), .CNT_WIDTH(4)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .add_i(add[0]), .wen_i(wen[0]),
    .wdata_i(wdata[0]), .be_i(be[0]), .id_i(id[0]), .gnt_o(gnt[0]), .r_valid_o(rv[0]),
    .r_rdata_o(rdata[0]), .r_opc_o(opc[0]), .r_id_o(rid[0]), .clear_i(clr[0]),
    .err_cnt_o(cnt_a), .err_valid_o(ev[0]), .err_addr_o(eaddr[0]), .err_id_o(eid[0]),
    .err_we_n_o(ewe[0]), .err_irq_o(irq[0])
  );

  periph_err_slave #(
    .RESP_LATENCY(3), .MAX_OUTSTANDING(1), .CNT_WIDTH(16)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .add_i(add[1]), .wen_i(wen[1]),
    .wdata_i(wdata[1]), .be_i(be[1]), .id_i(id[1]), .gnt_o(gnt[1]), .r_valid_o(rv[1]),
    .r_rdata_o(rdata[1]), .r_opc_o(opc[1]), .r_id_o(rid[1]), .clear_i(clr[1]),
    .err_cnt_o(cnt_b), .err_valid_o(ev[1]), .err_addr_o(eaddr[1]), .err_id_o(eid[1]),
    .err_we_n_o(ewe[1]), .err_irq_o(irq[1])
  );

  int lat  [2] = '{2, 3};
  int maxo [2] = '{2, 1};
  int cmax [2] = '{15, 65535};

  // Reference model: a table of scheduled responses indexed by the cycle they are due.
  bit          sv  [2][NCYC];
  logic [12:0] sid [2][NCYC];
  bit          swe [2][NCYC];
  int          pend [2];
  int          mcnt [2];
  bit          mev  [2];
  logic [31:0] maddr [2];
  logic [12:0] mid  [2];
  bit          mwe  [2];
  bit          mirq [2];

  int cyc;
  bit checking;
  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    bit          v;
    bit          g;
    bit          acc;
    string       p;
    logic [31:0] cnt_obs;
    for (int i = 0; i < 2; i++) begin
      p       = (i == 0) ? "a" : "b";
      v       = sv[i][cyc];
      g       = (pend[i] < maxo[i]) || v;
      cnt_obs = (i == 0) ? 32'(cnt_a) : 32'(cnt_b);
      if (checking) begin
        check_eq({p, ".gnt"}, 32'(gnt[i]), 32'(g));
        check_eq({p, ".r_valid"}, 32'(rv[i]), 32'(v));
        check_eq({p, ".r_opc"}, 32'(opc[i]), 32'(v));
        check_eq({p, ".r_id"}, 32'(rid[i]), v ? 32'(sid[i][cyc]) : 32'd0);
        check_eq({p, ".r_rdata"}, rdata[i], (v && swe[i][cyc]) ? 32'hBADCAB1E : 32'd0);
        check_eq({p, ".err_cnt"}, cnt_obs, 32'(mcnt[i]));
        check_eq({p, ".err_valid"}, 32'(ev[i]), 32'(mev[i]));
        check_eq({p, ".err_addr"}, eaddr[i], maddr[i]);
        check_eq({p, ".err_id"}, 32'(eid[i]), 32'(mid[i]));
        check_eq({p, ".err_we_n"}, 32'(ewe[i]), 32'(mwe[i]));
        check_eq({p, ".err_irq"}, 32'(irq[i]), 32'(mirq[i]));
      end
      if (!rst_n) begin
        pend[i] = 0; mcnt[i] = 0; mev[i] = 0; maddr[i] = '0; mid[i] = '0;
        mwe[i] = 0; mirq[i] = 0;
        for (int k = cyc + 1; k < NCYC; k++) sv[i][k] = 0;
      end else begin
        acc     = req[i] && g;
        pend[i] = pend[i] + int'(acc) - int'(v);
        mirq[i] = 0;
        if (clr[i]) begin
          mcnt[i] = 0;
          mev[i]  = 0;
        end
        if (acc) begin
          if (mcnt[i] < cmax[i]) mcnt[i]++;
          if (!mev[i]) begin
            mev[i] = 1; maddr[i] = add[i]; mid[i] = id[i]; mwe[i] = wen[i]; mirq[i] = 1;
          end
          sv[i][cyc + lat[i]]  = 1;
          sid[i][cyc + lat[i]] = id[i];
          swe[i][cyc + lat[i]] = wen[i];
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input int p_req, input int p_clr);
    req[i]   = ($urandom_range(0, 99) < p_req);
    clr[i]   = ($urandom_range(0, 99) < p_clr);
    add[i]   = $urandom;
    wen[i]   = 1'($urandom);
    wdata[i] = $urandom;
    be[i]    = 4'($urandom);
    id[i]    = 13'd1 << $urandom_range(0, 12);
  endtask

  task automatic run_random(input int n, input int p_req, input int p_clr);
    for (int c = 0; c < n; c++) begin
      drive(0, p_req, p_clr);
      drive(1, p_req, p_clr);
      tick();
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    checking = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; clr[i] = 0; add[i] = '0; wen[i] = 0; wdata[i] = '0; be[i] = '0; id[i] = '0;
    end
    @(posedge clk);
    #1;
    tick();
    tick();
    rst_n    = 1'b1;
    checking = 1;

    // Single read right after reset.
    for (int i = 0; i < 2; i++) begin
      req[i] = 1; add[i] = 32'h1020_0400; id[i] = 13'h0004; wen[i] = 1;
    end
    tick();
    for (int i = 0; i < 2; i++) req[i] = 0;
    repeat (4) tick();

    // Clear colliding with an accept at address 0xA while a response is in flight.
    for (int i = 0; i < 2; i++) begin
      req[i] = 1; add[i] = 32'h40; id[i] = 13'h0100; wen[i] = 0;
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      clr[i] = 1; add[i] = 32'hA; id[i] = 13'h0020;
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      clr[i] = 0; req[i] = 0;
    end
    repeat (5) tick();

    run_random(300, 70, 5);
    // Sustained requests: full throughput on a, one grant in three on b, a saturates.
    run_random(40, 100, 0);

    // Reset with responses in flight.
    for (int i = 0; i < 2; i++) begin
      req[i] = 1; clr[i] = 0;
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) req[i] = 0;
    repeat (6) tick();

    run_random(200, 50, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
